// File: rtl/wb_write_queue.sv
// Write-back queue in front of the register file write port.
// Buffers write-back results, drains one per cycle in push order, filters x0
// writes, and forwards the youngest pending value to two operand read ports.
module wb_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WB_VALID,
    output logic                         WB_READY,
    input  logic [ADDR_W-1:0]            WB_REG,
    input  logic [DATA_W-1:0]            WB_DATA,
    input  logic                         DRAIN_EN,
    input  logic                         FLUSH,
    output logic                         RegWEN,
    output logic [ADDR_W-1:0]            WRITE_REG,
    output logic [DATA_W-1:0]            REG_DATA_W,
    input  logic [ADDR_W-1:0]            FWD_REG_A,
    output logic                         FWD_HIT_A,
    output logic [DATA_W-1:0]            FWD_DATA_A,
    input  logic [ADDR_W-1:0]            FWD_REG_B,
    output logic                         FWD_HIT_B,
    output logic [DATA_W-1:0]            FWD_DATA_B,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         EMPTY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_reg   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_fdata_a;
    logic [DATA_W-1:0] w_fdata_b;

    assign w_empty = (r_count == '0);
    // Full check deliberately ignores a same-cycle pop to keep WB_READY off the drain path.
    assign w_ready = (r_count < CNT_W'(DEPTH)) && !FLUSH;
    // A handshake on x0 completes but never allocates an entry.
    assign w_push  = WB_VALID && w_ready && (WB_REG != '0);
    assign w_pop   = !w_empty && DRAIN_EN;

    // Queue state: flush clears everything, otherwise push at tail and pop at head.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_reg[PTR_W'(i)]  <= '0;
                r_data[PTR_W'(i)] <= '0;
            end
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_reg[r_wr_ptr]   <= WB_REG;
                r_data[r_wr_ptr]  <= WB_DATA;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit_a   = 1'b0;
        w_hit_b   = 1'b0;
        w_fdata_a = '0;
        w_fdata_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[PTR_W'(r_rd_ptr + PTR_W'(i))]) begin
                if ((FWD_REG_A != '0) && (r_reg[PTR_W'(r_rd_ptr + PTR_W'(i))] == FWD_REG_A)) begin
                    w_hit_a   = 1'b1;
                    w_fdata_a = r_data[PTR_W'(r_rd_ptr + PTR_W'(i))];
                end
                if ((FWD_REG_B != '0) && (r_reg[PTR_W'(r_rd_ptr + PTR_W'(i))] == FWD_REG_B)) begin
                    w_hit_b   = 1'b1;
                    w_fdata_b = r_data[PTR_W'(r_rd_ptr + PTR_W'(i))];
                end
            end
        end
    end

    assign WB_READY   = w_ready;
    assign RegWEN     = w_pop;
    assign WRITE_REG  = w_empty ? '0 : r_reg[r_rd_ptr];
    assign REG_DATA_W = w_empty ? '0 : r_data[r_rd_ptr];
    assign FWD_HIT_A  = w_hit_a;
    assign FWD_DATA_A = w_fdata_a;
    assign FWD_HIT_B  = w_hit_b;
    assign FWD_DATA_B = w_fdata_b;
    assign COUNT      = r_count;
    assign EMPTY      = w_empty;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: vector table plus reset, wrap and flush sequences.
module tb_wb_write_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_VALID;
    logic        WB_READY;
    logic [4:0]  WB_REG;
    logic [31:0] WB_DATA;
    logic        DRAIN_EN;
    logic        FLUSH;
    logic        RegWEN;
    logic [4:0]  WRITE_REG;
    logic [31:0] REG_DATA_W;
    logic [4:0]  FWD_REG_A;
    logic        FWD_HIT_A;
    logic [31:0] FWD_DATA_A;
    logic [4:0]  FWD_REG_B;
    logic        FWD_HIT_B;
    logic [31:0] FWD_DATA_B;
    logic [2:0]  COUNT;
    logic        EMPTY;

    int n_vec = 0;
    int n_err = 0;

    wb_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_REG(WB_REG), .WB_DATA(WB_DATA),
        .DRAIN_EN(DRAIN_EN), .FLUSH(FLUSH),
        .RegWEN(RegWEN), .WRITE_REG(WRITE_REG), .REG_DATA_W(REG_DATA_W),
        .FWD_REG_A(FWD_REG_A), .FWD_HIT_A(FWD_HIT_A), .FWD_DATA_A(FWD_DATA_A),
        .FWD_REG_B(FWD_REG_B), .FWD_HIT_B(FWD_HIT_B), .FWD_DATA_B(FWD_DATA_B),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        de;
        logic        fl;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        e_rdy;
        logic        e_wen;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_ha;
        logic [31:0] e_da;
        logic        e_hb;
        logic [31:0] e_db;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        logic v, logic [4:0] r, logic [31:0] d, logic de, logic fl, logic [4:0] a, logic [4:0] b,
        logic rdy, logic wen, logic [4:0] wreg, logic [31:0] wdata,
        logic ha, logic [31:0] da, logic hb, logic [31:0] db, logic [2:0] cnt);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.de = de; t.fl = fl; t.a = a; t.b = b;
        t.e_rdy = rdy; t.e_wen = wen; t.e_wreg = wreg; t.e_wdata = wdata;
        t.e_ha = ha; t.e_da = da; t.e_hb = hb; t.e_db = db; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic de, input logic fl, input logic [4:0] a, input logic [4:0] b);
        WB_VALID = v; WB_REG = r; WB_DATA = d; DRAIN_EN = de; FLUSH = fl;
        FWD_REG_A = a; FWD_REG_B = b;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    logic [4:0]  q_reg[$];
    logic [31:0] q_dat[$];

    initial begin
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("rst.count", 32'(COUNT), 0);
        check("rst.empty", 32'(EMPTY), 1);
        check("rst.regwen", 32'(RegWEN), 0);
        check("rst.ready", 32'(WB_READY), 1);
        check("rst.wreg", 32'(WRITE_REG), 0);
        check("rst.hit_a", 32'(FWD_HIT_A), 0);
        next_cycle();

        // order / latency
        vq.push_back(mk(1, 5, 'h11, 1, 0, 5, 0,  1, 0, 0, 0,     0, 0,     0, 0,     0));
        vq.push_back(mk(1, 6, 'h22, 1, 0, 5, 6,  1, 1, 5, 'h11,  1, 'h11,  0, 0,     1));
        vq.push_back(mk(1, 5, 'h33, 1, 0, 5, 6,  1, 1, 6, 'h22,  0, 0,     1, 'h22,  1));
        vq.push_back(mk(0, 0, 0,    1, 0, 5, 6,  1, 1, 5, 'h33,  1, 'h33,  0, 0,     1));
        vq.push_back(mk(0, 0, 0,    0, 0, 5, 6,  1, 0, 0, 0,     0, 0,     0, 0,     0));
        // full / backpressure
        vq.push_back(mk(1, 1, 'hA1, 0, 0, 1, 2,  1, 0, 0, 0,     0, 0,     0, 0,     0));
        vq.push_back(mk(1, 2, 'hA2, 0, 0, 1, 2,  1, 0, 1, 'hA1,  1, 'hA1,  0, 0,     1));
        vq.push_back(mk(1, 1, 'hB1, 0, 0, 1, 2,  1, 0, 1, 'hA1,  1, 'hA1,  1, 'hA2,  2));
        vq.push_back(mk(1, 3, 'hA3, 0, 0, 1, 3,  1, 0, 1, 'hA1,  1, 'hB1,  0, 0,     3));
        vq.push_back(mk(1, 4, 'hA4, 0, 0, 3, 4,  0, 0, 1, 'hA1,  1, 'hA3,  0, 0,     4));
        vq.push_back(mk(1, 4, 'hA4, 1, 0, 4, 1,  0, 1, 1, 'hA1,  0, 0,     1, 'hB1,  4));
        vq.push_back(mk(1, 4, 'hA4, 0, 0, 4, 1,  1, 0, 2, 'hA2,  0, 0,     1, 'hB1,  3));
        vq.push_back(mk(0, 0, 0,    1, 0, 4, 2,  0, 1, 2, 'hA2,  1, 'hA4,  1, 'hA2,  4));
        vq.push_back(mk(0, 0, 0,    1, 0, 4, 2,  1, 1, 1, 'hB1,  1, 'hA4,  0, 0,     3));
        vq.push_back(mk(0, 0, 0,    1, 0, 4, 2,  1, 1, 3, 'hA3,  1, 'hA4,  0, 0,     2));
        vq.push_back(mk(0, 0, 0,    1, 0, 4, 2,  1, 1, 4, 'hA4,  1, 'hA4,  0, 0,     1));
        // x0 filter
        vq.push_back(mk(1, 0, 'hDEAD, 1, 0, 0, 0, 1, 0, 0, 0,    0, 0,     0, 0,     0));
        vq.push_back(mk(0, 0, 0,    1, 0, 0, 0,  1, 0, 0, 0,     0, 0,     0, 0,     0));
        // forwarding, then flush with pending entries and a dropped push
        vq.push_back(mk(1, 7, 1,     0, 0, 7, 8, 1, 0, 0, 0,     0, 0,     0, 0,     0));
        vq.push_back(mk(1, 7, 2,     0, 0, 7, 8, 1, 0, 7, 1,     1, 1,     0, 0,     1));
        vq.push_back(mk(1, 9, 'h99,  0, 0, 7, 8, 1, 0, 7, 1,     1, 2,     0, 0,     2));
        vq.push_back(mk(1, 8, 'h88,  1, 1, 8, 7, 0, 1, 7, 1,     0, 0,     1, 2,     3));
        vq.push_back(mk(0, 0, 0,     1, 0, 8, 7, 1, 0, 0, 0,     0, 0,     0, 0,     0));

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].r, vq[i].d, vq[i].de, vq[i].fl, vq[i].a, vq[i].b);
            #2;
            check($sformatf("v%0d.ready", i), 32'(WB_READY), 32'(vq[i].e_rdy));
            check($sformatf("v%0d.regwen", i), 32'(RegWEN), 32'(vq[i].e_wen));
            check($sformatf("v%0d.wreg", i), 32'(WRITE_REG), 32'(vq[i].e_wreg));
            check($sformatf("v%0d.wdata", i), REG_DATA_W, vq[i].e_wdata);
            check($sformatf("v%0d.hit_a", i), 32'(FWD_HIT_A), 32'(vq[i].e_ha));
            check($sformatf("v%0d.data_a", i), FWD_DATA_A, vq[i].e_da);
            check($sformatf("v%0d.hit_b", i), 32'(FWD_HIT_B), 32'(vq[i].e_hb));
            check($sformatf("v%0d.data_b", i), FWD_DATA_B, vq[i].e_db);
            check($sformatf("v%0d.count", i), 32'(COUNT), 32'(vq[i].e_cnt));
            check($sformatf("v%0d.empty", i), 32'(EMPTY), 32'(vq[i].e_cnt == 3'd0));
            next_cycle();
        end

        // async reset while draining three pending entries
        drive(1, 10, 'h10, 0, 0, 0, 0); next_cycle();
        drive(1, 11, 'h11, 0, 0, 0, 0); next_cycle();
        drive(1, 12, 'h12, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 1, 0, 10, 0);
        #2;
        check("rstmid.pre_regwen", 32'(RegWEN), 1);
        check("rstmid.pre_count", 32'(COUNT), 3);
        check("rstmid.pre_wreg", 32'(WRITE_REG), 10);
        RST = 1'b0;
        #1;
        check("rstmid.regwen", 32'(RegWEN), 0);
        check("rstmid.count", 32'(COUNT), 0);
        check("rstmid.empty", 32'(EMPTY), 1);
        check("rstmid.hit_a", 32'(FWD_HIT_A), 0);
        check("rstmid.wreg", 32'(WRITE_REG), 0);
        next_cycle();
        RST = 1'b1;
        #1;
        check("rstmid.ready", 32'(WB_READY), 1);
        check("rstmid.post_count", 32'(COUNT), 0);
        next_cycle();

        // ten entries streamed through with drain enabled, wrapping the pointers
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(1, 5'(i % 7 + 1), 32'hC000 + 32'(i), 1, 0, 0, 0);
            else        drive(0, 0, 0, 1, 0, 0, 0);
            #2;
            check($sformatf("wrap%0d.count", i), 32'(COUNT), 32'(q_reg.size()));
            check($sformatf("wrap%0d.regwen", i), 32'(RegWEN), 32'(q_reg.size() != 0));
            if (q_reg.size() != 0) begin
                check($sformatf("wrap%0d.wreg", i), 32'(WRITE_REG), 32'(q_reg[0]));
                check($sformatf("wrap%0d.wdata", i), REG_DATA_W, q_dat[0]);
                void'(q_reg.pop_front());
                void'(q_dat.pop_front());
            end
            if (WB_VALID && WB_REG != 5'd0) begin
                q_reg.push_back(WB_REG);
                q_dat.push_back(WB_DATA);
            end
            next_cycle();
        end

        // flush with two pending entries, head committing and a push in the same cycle
        drive(1, 20, 'h20, 0, 0, 0, 0); next_cycle();
        drive(1, 21, 'h21, 0, 0, 0, 0); next_cycle();
        drive(1, 22, 'h22, 1, 1, 21, 22);
        #2;
        check("flush.count", 32'(COUNT), 2);
        check("flush.ready", 32'(WB_READY), 0);
        check("flush.regwen", 32'(RegWEN), 1);
        check("flush.wreg", 32'(WRITE_REG), 20);
        check("flush.wdata", REG_DATA_W, 'h20);
        check("flush.hit_a", 32'(FWD_HIT_A), 1);
        check("flush.hit_b", 32'(FWD_HIT_B), 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 22, 21);
            #2;
            check($sformatf("postflush%0d.count", i), 32'(COUNT), 0);
            check($sformatf("postflush%0d.regwen", i), 32'(RegWEN), 0);
            check($sformatf("postflush%0d.hit_a", i), 32'(FWD_HIT_A), 0);
            check($sformatf("postflush%0d.hit_b", i), 32'(FWD_HIT_B), 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
